mxu_wrapper: RTL and testbench

- Parameterised M×K integer matrix-multiply unit; computes one vector-matrix product y = aᵀ·W per enabled cycle.
- Used as the compute kernel of the DTPU datapath.
- Operand precision is selected at run time (INT8/16/32/64) inside fixed 64-bit lanes.
- Input, chain and output register stages can each be enabled or bypassed individually.

---
 rtl/mxu_pkg.sv | 55 +++++
 rtl/mxu_mac_row.sv | 40 ++++
 rtl/mxu_wrapper.sv | 142 ++++++++++++++
 tb/tb_mxu_wrapper.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mxu_pkg.sv
// Precision codes and operand helpers shared by the matrix-multiply unit.
// Lane width is fixed at 64 bits; narrower precisions live in the low bits of a lane.
package mxu_pkg;

    localparam int LOG_ALLOWED_PRECISIONS = 2;
    localparam int LANE_W = 64;

    localparam logic [LOG_ALLOWED_PRECISIONS-1:0] INT8  = 2'd0;
    localparam logic [LOG_ALLOWED_PRECISIONS-1:0] INT16 = 2'd1;
    localparam logic [LOG_ALLOWED_PRECISIONS-1:0] INT32 = 2'd2;
    localparam logic [LOG_ALLOWED_PRECISIONS-1:0] INT64 = 2'd3;

    function automatic int unsigned prec_width(input logic [LOG_ALLOWED_PRECISIONS-1:0] dt);
        case (dt)
            INT8:    return 8;
            INT16:   return 16;
            INT32:   return 32;
            default: return 64;
        endcase
    endfunction

    function automatic logic [LANE_W-1:0] sign_ext(input logic [LANE_W-1:0] v,
                                                   input logic [LOG_ALLOWED_PRECISIONS-1:0] dt);
        case (dt)
            INT8:    return {{56{v[7]}}, v[7:0]};
            INT16:   return {{48{v[15]}}, v[15:0]};
            INT32:   return {{32{v[31]}}, v[31:0]};
            default: return v;
        endcase
    endfunction

    // Clamp a 64-bit two's-complement value to the signed range of the selected precision.
    function automatic logic [LANE_W-1:0] saturate(input logic [LANE_W-1:0] v,
                                                   input logic [LOG_ALLOWED_PRECISIONS-1:0] dt);
        logic signed [LANE_W-1:0] s;
        logic signed [LANE_W-1:0] hi;
        logic signed [LANE_W-1:0] lo;
        int unsigned n;
        n  = prec_width(dt);
        s  = signed'(v);
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (n >= LANE_W) begin
            return v;
        end
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/mxu_mac_row.sv
// One matrix row: K multiply-accumulate cells adding a*w[k] onto the incoming partial sums,
// with an optional partial-sum register used by the systolic chain.
module mxu_mac_row
    import mxu_pkg::*;
#(
    parameter int K = 3,
    parameter int W = LANE_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic           reg_en,
    input  logic [W-1:0]   a,
    input  logic [K*W-1:0] w,
    input  logic [K*W-1:0] psum_in,
    output logic [K*W-1:0] psum_out
);

    logic [K*W-1:0] sum;
    logic [K*W-1:0] psum_q;

    // Products and sums keep only the low W bits: modulo 2^W wrap.
    always_comb begin
        sum = '0;
        for (int k = 0; k < K; k++) begin
            sum[k*W +: W] = psum_in[k*W +: W] + a * w[k*W +: W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psum_q <= '0;
        end else if (enable) begin
            psum_q <= sum;
        end
    end

    assign psum_out = reg_en ? psum_q : sum;

endmodule

// File: rtl/mxu_wrapper.sv
// M x K integer vector-matrix multiply with optional input, chain and output register stages.
// Build option: define MXU_SATURATE_EN to saturate each result lane to the selected precision.
module mxu_wrapper
    import mxu_pkg::*;
#(
    parameter int M              = 3,
    parameter int K              = 3,
    parameter int max_data_width = 64,
    parameter int MAX_BOARD_DSP  = 220
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [LOG_ALLOWED_PRECISIONS-1:0] data_type,
    input  logic                              enable_in_ff,
    input  logic                              enable_chain,
    input  logic                              enable_out_ff,
    input  logic [1:0]                        enable_fp_unit,
    input  logic                              test_mode,
    input  logic [max_data_width*M-1:0]       input_data,
    input  logic [max_data_width*M*K-1:0]     weight,
    output logic [max_data_width*K-1:0]       y
);

    localparam int W  = max_data_width;
    localparam int RW = (K + 1) * W;

    if (M * K > MAX_BOARD_DSP) begin : g_dsp_budget
        $error("mxu_wrapper: M*K exceeds MAX_BOARD_DSP");
    end
    if (W != LANE_W) begin : g_lane_width
        $error("mxu_wrapper: max_data_width must be 64");
    end

    logic unused_fp;
    assign unused_fp = ^enable_fp_unit;

    logic [M*W-1:0]   in_q;
    logic [M*K*W-1:0] w_q;
    logic [M*W-1:0]   a_s;
    logic [M*K*W-1:0] w_s;
    logic [M*W-1:0]   a_x;
    logic [M*K*W-1:0] w_x;
    logic [K*W-1:0]   psum [M+1];
    logic [K*W-1:0]   y_comb;
    logic [K*W-1:0]   y_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q <= '0;
            w_q  <= '0;
        end else if (enable) begin
            in_q <= input_data;
            w_q  <= weight;
        end
    end

    assign a_s = enable_in_ff ? in_q : input_data;
    assign w_s = enable_in_ff ? w_q : weight;

    always_comb begin
        a_x = '0;
        w_x = '0;
        for (int m = 0; m < M; m++) begin
            a_x[m*W +: W] = sign_ext(a_s[m*W +: W], data_type);
            for (int k = 0; k < K; k++) begin
                w_x[(m*K+k)*W +: W] = sign_ext(w_s[(m*K+k)*W +: W], data_type);
            end
        end
    end

    assign psum[0] = '0;

    for (genvar m = 0; m < M; m++) begin : g_row
        logic [RW-1:0] op_now;
        logic [RW-1:0] op_row;
        logic          reg_en;

        assign op_now = {w_x[m*K*W +: K*W], a_x[m*W +: W]};
        assign reg_en = enable_chain && (m < M - 1);

        // Row m sees its operands m cycles late so it meets the partial sum of the same vector.
        if (m > 0) begin : g_dly
            logic [RW-1:0] dly_q [m];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < m; i++) begin
                        dly_q[i] <= '0;
                    end
                end else if (enable) begin
                    dly_q[0] <= op_now;
                    for (int i = 1; i < m; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end
            assign op_row = enable_chain ? dly_q[m-1] : op_now;
        end else begin : g_nodly
            assign op_row = op_now;
        end

        mxu_mac_row #(
            .K (K),
            .W (W)
        ) u_row (
            .clk      (clk),
            .reset    (reset),
            .enable   (enable),
            .reg_en   (reg_en),
            .a        (op_row[W-1:0]),
            .w        (op_row[RW-1:W]),
            .psum_in  (psum[m]),
            .psum_out (psum[m+1])
        );
    end

    always_comb begin
        y_comb = '0;
        for (int k = 0; k < K; k++) begin
            if (test_mode) begin
                y_comb[k*W +: W] = a_x[(k % M)*W +: W];
            end else begin
`ifdef MXU_SATURATE_EN
                y_comb[k*W +: W] = saturate(psum[M][k*W +: W], data_type);
`else
                y_comb[k*W +: W] = psum[M][k*W +: W];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q <= '0;
        end else if (enable) begin
            y_q <= y_comb;
        end
    end

    assign y = enable_out_ff ? y_q : y_comb;

endmodule

// File: tb/tb_mxu_wrapper.sv
// Self-checking bench for mxu_wrapper (M=K=4): random vector streams against a behavioural model.
module tb_mxu_wrapper;

    localparam int M = 4;
    localparam int K = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [1:0]        data_type;
    logic              enable_in_ff;
    logic              enable_chain;
    logic              enable_out_ff;
    logic [1:0]        enable_fp_unit;
    logic              test_mode;
    logic [M*64-1:0]   input_data;
    logic [M*K*64-1:0] weight;
    logic [K*64-1:0]   y;

    int checks   = 0;
    int failures = 0;

    mxu_wrapper #(
        .M              (M),
        .K              (K),
        .max_data_width (64),
        .MAX_BOARD_DSP  (220)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .data_type      (data_type),
        .enable_in_ff   (enable_in_ff),
        .enable_chain   (enable_chain),
        .enable_out_ff  (enable_out_ff),
        .enable_fp_unit (enable_fp_unit),
        .test_mode      (test_mode),
        .input_data     (input_data),
        .weight         (weight),
        .y              (y)
    );

    always #5 clk = ~clk;

    // Value of the low (8<<dt) bits of v read as a signed integer.
    function automatic longint sx(input logic [63:0] v, input logic [1:0] dt);
        int n;
        longint r;
        n = 8 << dt;
        if (n == 64) return longint'(v);
        r = longint'(v & ((64'd1 << n) - 64'd1));
        if (r >= (64'sd1 <<< (n - 1))) r = r - (64'sd1 <<< n);
        return r;
    endfunction

    function automatic logic [K*64-1:0] model(input logic [M*64-1:0] a,
                                              input logic [M*K*64-1:0] w,
                                              input logic [1:0] dt, input bit tm);
        logic [K*64-1:0] r;
        longint acc;
        r = '0;
        for (int k = 0; k < K; k++) begin
            if (tm) begin
                r[k*64 +: 64] = sx(a[(k % M)*64 +: 64], dt);
            end else begin
                acc = 0;
                for (int m = 0; m < M; m++) begin
                    acc += sx(a[m*64 +: 64], dt) * sx(w[(m*K+k)*64 +: 64], dt);
                end
`ifdef MXU_SATURATE_EN
                begin
                    int n;
                    longint hi;
                    n = 8 << dt;
                    if (n < 64) begin
                        hi = (64'sd1 <<< (n - 1)) - 1;
                        if (acc > hi) acc = hi;
                        else if (acc < -hi - 1) acc = -hi - 1;
                    end
                end
`endif
                r[k*64 +: 64] = acc;
            end
        end
        return r;
    endfunction

    task automatic rand_inputs();
        for (int i = 0; i < M; i++) input_data[i*64 +: 64] = {$urandom, $urandom};
        for (int i = 0; i < M*K; i++) weight[i*64 +: 64] = {$urandom, $urandom};
    endtask

    task automatic set_ctrl(input bit inf, input bit ch, input bit outf, input bit tm,
                            input logic [1:0] dt);
        enable_in_ff  = inf;
        enable_chain  = ch;
        enable_out_ff = outf;
        test_mode     = tm;
        data_type     = dt;
    endtask

    // Drive a new random vector every cycle; each sample must equal the vector from L steps back.
    task automatic run_stream(input string name, input bit inf, input bit ch, input bit outf,
                              input bit tm, input logic [1:0] dt, input int n,
                              output logic [K*64-1:0] last_exp);
        logic [K*64-1:0] exp_v [0:63];
        int lat;
        lat = int'(inf) + int'(outf) + ((ch && !tm) ? M - 1 : 0);
        last_exp = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) set_ctrl(inf, ch, outf, tm, dt);
            rand_inputs();
            exp_v[i] = model(input_data, weight, dt, tm);
            #1;
            if (i >= lat) begin
                checks++;
                last_exp = exp_v[i-lat];
                if (y !== exp_v[i-lat]) begin
                    failures++;
                    $display("FAIL %s step %0d: y=%h expected %h", name, i, y, exp_v[i-lat]);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [K*64-1:0] zero;
        zero = '0;
        reset = 1'b1;
        enable = 1'b1;
        enable_fp_unit = 2'b00;
        set_ctrl(1, 1, 1, 0, 2'd3);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rand_inputs();
            #1;
            checks++;
            if (y !== zero) begin
                failures++;
                $display("FAIL reset_state cycle %0d: y=%h expected 0", i, y);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed_int8();
        logic [63:0] e;
`ifdef MXU_SATURATE_EN
        e = 64'd127;
`else
        e = 64'd216;
`endif
        @(negedge clk);
        set_ctrl(1, 0, 1, 0, 2'd0);
        for (int i = 0; i < M; i++) input_data[i*64 +: 64] = 64'h0000_0000_0000_00CA;
        for (int i = 0; i < M*K; i++) weight[i*64 +: 64] = 64'h0000_0000_0000_00FF;
        @(negedge clk);
        @(negedge clk);
        #1;
        for (int k = 0; k < K; k++) begin
            checks++;
            if (y[k*64 +: 64] !== e) begin
                failures++;
                $display("FAIL int8_directed lane %0d: y=%h expected %h", k, y[k*64 +: 64], e);
            end
        end
    endtask

    task automatic test_directed_int16_garbage();
        logic [63:0] e;
`ifdef MXU_SATURATE_EN
        e = 64'hFFFF_FFFF_FFFF_8000;
`else
        e = 64'hFFFF_FFFF_FFFC_0000;
`endif
        @(negedge clk);
        set_ctrl(1, 0, 1, 0, 2'd1);
        for (int i = 0; i < M; i++) input_data[i*64 +: 64] = {$urandom, $urandom[15:0], 16'h8000};
        for (int i = 0; i < M*K; i++) weight[i*64 +: 64] = {$urandom, $urandom[15:0], 16'h0002};
        @(negedge clk);
        @(negedge clk);
        #1;
        for (int k = 0; k < K; k++) begin
            checks++;
            if (y[k*64 +: 64] !== e) begin
                failures++;
                $display("FAIL int16_garbage lane %0d: y=%h expected %h", k, y[k*64 +: 64], e);
            end
        end
    endtask

    task automatic test_config_sweep();
        logic [K*64-1:0] le;
        for (int c = 0; c < 8; c++) begin
            for (int d = 0; d < 4; d++) begin
                run_stream($sformatf("stream_cfg%0d_dt%0d", c, d), c[0], c[1], c[2], 1'b0,
                           2'(d), 10, le);
            end
        end
    endtask

    task automatic test_chain_latency();
        logic [K*64-1:0] le;
        run_stream("chain_full_pipe", 1, 1, 1, 0, 2'd2, 24, le);
    endtask

    task automatic test_midreset();
        logic [K*64-1:0] le;
        logic [K*64-1:0] zero;
        zero = '0;
        run_stream("pre_reset", 1, 1, 1, 0, 2'd3, 8, le);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (y !== zero) begin
            failures++;
            $display("FAIL async_reset: y=%h expected 0", y);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_freeze();
        logic [K*64-1:0] le;
        run_stream("pre_freeze", 1, 1, 1, 0, 2'd1, 12, le);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rand_inputs();
            #1;
            checks++;
            if (y !== le) begin
                failures++;
                $display("FAIL freeze cycle %0d: y=%h expected %h", i, y, le);
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_test_mode();
        logic [K*64-1:0] le;
        logic [K*64-1:0] e;
        @(negedge clk);
        set_ctrl(1, 1, 1, 1, 2'd3);
        for (int i = 0; i < M; i++) input_data[i*64 +: 64] = 64'(i + 1);
        rand_inputs_weights_only();
        @(negedge clk);
        @(negedge clk);
        #1;
        for (int k = 0; k < K; k++) e[k*64 +: 64] = 64'((k % M) + 1);
        checks++;
        if (y !== e) begin
            failures++;
            $display("FAIL test_mode_directed: y=%h expected %h", y, e);
        end
        run_stream("test_mode_int8", 1, 1, 1, 1, 2'd0, 8, le);
        run_stream("test_mode_bypass", 0, 0, 0, 1, 2'd2, 6, le);
    endtask

    task automatic rand_inputs_weights_only();
        for (int i = 0; i < M*K; i++) weight[i*64 +: 64] = {$urandom, $urandom};
    endtask

    initial begin
        input_data = '0;
        weight = '0;
        test_reset();
        test_directed_int8();
        test_directed_int16_garbage();
        test_config_sweep();
        test_chain_latency();
        test_midreset();
        test_freeze();
        test_test_mode();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
